idu_queue: RTL and testbench

Parametrised successor to the single-entry instruction decode stage, sitting between IFU and LSU. It buffers up to DEPTH fetched instructions in a FIFO and decodes the head into a one-hot operation and SRAM select. It drops illegal encodings with a sticky error and count, and holds dispatch after a WFI until the LSU reports completion. Field extraction for dram address, lengths, strides and matrix directions stays with the LSU, which receives the raw head instruction alongside the decode.

---
 rtl/idu_pkg.sv | 52 +++++
 rtl/idu_sync_fifo.sv | 63 ++++++
 rtl/idu_queue.sv | 169 ++++++++++++++++
 tb/tb_idu_queue.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/idu_pkg.sv
// Shared decode constants for the instruction decode queue: opcode and SRAM-type
// codes, field positions as functions of instruction width, and one-hot bit indices.
package idu_pkg;

  localparam logic [3:0] OPC_LD   = 4'h1;
  localparam logic [3:0] OPC_ST   = 4'h2;
  localparam logic [3:0] OPC_STM  = 4'h3;
  localparam logic [3:0] OPC_MM   = 4'h4;
  localparam logic [3:0] OPC_ACT  = 4'h5;
  localparam logic [3:0] OPC_POOL = 4'h6;
  localparam logic [3:0] OPC_WFI  = 4'hF;

  localparam logic [1:0] SRAM_IRAM = 2'b00;
  localparam logic [1:0] SRAM_ORAM = 2'b01;
  localparam logic [1:0] SRAM_WRAM = 2'b10;

  localparam int OP_W         = 7;
  localparam int OP_LD_BIT    = 0;
  localparam int OP_ST_BIT    = 1;
  localparam int OP_STM_BIT   = 2;
  localparam int OP_MM_BIT    = 3;
  localparam int OP_ACT_BIT   = 4;
  localparam int OP_POOL_BIT  = 5;
  localparam int OP_WFI_BIT   = 6;

  localparam int SEL_W        = 3;
  localparam int SEL_IRAM_BIT = 0;
  localparam int SEL_WRAM_BIT = 1;
  localparam int SEL_ORAM_BIT = 2;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_WFI_WAIT = 1'b1
  } idu_state_e;

  function automatic int op_msb(input int ins_w);
    return ins_w - 1;
  endfunction

  function automatic int op_lsb(input int ins_w);
    return ins_w - 4;
  endfunction

  function automatic int sram_msb(input int ins_w);
    return ins_w - 5;
  endfunction

  function automatic int sram_lsb(input int ins_w);
    return ins_w - 6;
  endfunction

endpackage

// File: rtl/idu_sync_fifo.sv
// Synchronous FIFO with registered occupancy and a flush that wins over push/pop.
// The read port reads zero whenever the FIFO is empty.
module idu_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign empty     = (count_r == '0);
  assign full      = (count_r == CW'(DEPTH));
  assign do_push_s = push & ~flush & ~full;
  assign do_pop_s  = pop & ~flush & ~empty;
  assign count     = count_r;
  assign rdata     = empty ? '0 : mem_r[rd_ptr_r];

  // Storage write; contents are only observable through a valid read pointer.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers and occupancy; power-of-two depth makes the wrap implicit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/idu_queue.sv
// Instruction decode queue between IFU and LSU: buffers fetched instructions, decodes
// the head, drops illegal encodings with a sticky error, and stalls dispatch after WFI.
module idu_queue
  import idu_pkg::*;
#(
  parameter int INS_W = 64,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ifu_idu_vld,
  input  logic [INS_W-1:0] ifu_idu_ins,
  input  logic             ifu_idu_flush,
  output logic             idu_ifu_rdy,
  output logic             idu_ifu_wfi,
  output logic             idu_lsu_vld,
  output logic [OP_W-1:0]  idu_lsu_op,
  output logic [SEL_W-1:0] idu_lsu_sram_sel,
  output logic [INS_W-1:0] idu_lsu_ins,
  input  logic             lsu_idu_rdy,
  input  logic             lsu_idu_wfi_done,
  output logic             idu_err,
  output logic [7:0]       idu_err_cnt,
  output logic [CNT_W-1:0] idu_occ
);

  localparam int OP_MSB   = op_msb(INS_W);
  localparam int OP_LSB   = op_lsb(INS_W);
  localparam int SRAM_MSB = sram_msb(INS_W);
  localparam int SRAM_LSB = sram_lsb(INS_W);

  idu_state_e        state_r;
  idu_state_e        state_nxt_s;
  logic [INS_W-1:0]  head_s;
  logic [CNT_W-1:0]  occ_s;
  logic              empty_s;
  logic              full_s;
  logic              push_s;
  logic              pop_s;
  logic              err_inc_s;
  logic              legal_s;
  logic              head_ok_s;
  logic [3:0]        opc_s;
  logic [1:0]        sram_s;
  logic [OP_W-1:0]   op_dec_s;
  logic [SEL_W-1:0]  sel_dec_s;
  logic              err_r;
  logic [7:0]        err_cnt_r;

  // Ready looks at the registered count only, so a same-cycle pop never frees a slot.
  assign idu_ifu_rdy = ~ifu_idu_flush & ~full_s;
  assign push_s      = ifu_idu_vld & idu_ifu_rdy;

  idu_sync_fifo #(
    .WIDTH (INS_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .flush (ifu_idu_flush),
    .wdata (ifu_idu_ins),
    .rdata (head_s),
    .count (occ_s),
    .empty (empty_s),
    .full  (full_s)
  );

  // Head decode: one-hot op, SRAM select for LD/ST, and legality of the encoding.
  always_comb begin
    opc_s     = head_s[OP_MSB:OP_LSB];
    sram_s    = head_s[SRAM_MSB:SRAM_LSB];
    op_dec_s  = '0;
    sel_dec_s = '0;
    legal_s   = 1'b0;
    case (opc_s)
      OPC_LD: begin
        op_dec_s[OP_LD_BIT] = 1'b1;
        case (sram_s)
          SRAM_IRAM: begin sel_dec_s[SEL_IRAM_BIT] = 1'b1; legal_s = 1'b1; end
          SRAM_WRAM: begin sel_dec_s[SEL_WRAM_BIT] = 1'b1; legal_s = 1'b1; end
          default:   begin sel_dec_s = '0; legal_s = 1'b0; end
        endcase
      end
      OPC_ST: begin
        op_dec_s[OP_ST_BIT] = 1'b1;
        case (sram_s)
          SRAM_IRAM: begin sel_dec_s[SEL_IRAM_BIT] = 1'b1; legal_s = 1'b1; end
          SRAM_WRAM: begin sel_dec_s[SEL_WRAM_BIT] = 1'b1; legal_s = 1'b1; end
          SRAM_ORAM: begin sel_dec_s[SEL_ORAM_BIT] = 1'b1; legal_s = 1'b1; end
          default:   begin sel_dec_s = '0; legal_s = 1'b0; end
        endcase
      end
      OPC_STM:  begin op_dec_s[OP_STM_BIT]  = 1'b1; legal_s = 1'b1; end
      OPC_MM:   begin op_dec_s[OP_MM_BIT]   = 1'b1; legal_s = 1'b1; end
      OPC_ACT:  begin op_dec_s[OP_ACT_BIT]  = 1'b1; legal_s = 1'b1; end
      OPC_POOL: begin op_dec_s[OP_POOL_BIT] = 1'b1; legal_s = 1'b1; end
      OPC_WFI:  begin op_dec_s[OP_WFI_BIT]  = 1'b1; legal_s = 1'b1; end
      default:  begin op_dec_s = '0; legal_s = 1'b0; end
    endcase
  end

  assign head_ok_s        = legal_s & ~empty_s;
  assign idu_lsu_op       = head_ok_s ? op_dec_s  : '0;
  assign idu_lsu_sram_sel = head_ok_s ? sel_dec_s : '0;
  assign idu_lsu_ins      = head_s;
  assign idu_occ          = occ_s;
  assign idu_err          = err_r;
  assign idu_err_cnt      = err_cnt_r;

  // Dispatch control: legal heads wait for the LSU, illegal heads drop in one cycle.
  always_comb begin
    state_nxt_s = state_r;
    pop_s       = 1'b0;
    err_inc_s   = 1'b0;
    idu_lsu_vld = 1'b0;
    idu_ifu_wfi = 1'b0;
    case (state_r)
      ST_RUN: begin
        idu_lsu_vld = head_ok_s;
        if (head_ok_s) begin
          pop_s = lsu_idu_rdy;
          if (lsu_idu_rdy && op_dec_s[OP_WFI_BIT] && !ifu_idu_flush) begin
            state_nxt_s = ST_WFI_WAIT;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end else if (!empty_s) begin
          pop_s     = 1'b1;
          err_inc_s = ~ifu_idu_flush;
        end else begin
          pop_s = 1'b0;
        end
      end
      ST_WFI_WAIT: begin
        idu_ifu_wfi = 1'b1;
        if (lsu_idu_wfi_done) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_WFI_WAIT;
        end
      end
      default: state_nxt_s = ST_RUN;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Sticky error flag and saturating drop counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_r     <= 1'b0;
      err_cnt_r <= 8'd0;
    end else if (err_inc_s) begin
      err_r <= 1'b1;
      if (err_cnt_r != 8'hFF) err_cnt_r <= err_cnt_r + 8'd1;
    end
  end

endmodule

// File: tb/tb_idu_queue.sv
// Randomised self-checking bench for idu_queue against a queue-based reference model.
module tb_idu_queue;
  localparam int INS_W = 64;
  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             ifu_idu_vld = 1'b0;
  logic [INS_W-1:0] ifu_idu_ins = '0;
  logic             ifu_idu_flush = 1'b0;
  logic             idu_ifu_rdy;
  logic             idu_ifu_wfi;
  logic             idu_lsu_vld;
  logic [6:0]       idu_lsu_op;
  logic [2:0]       idu_lsu_sram_sel;
  logic [INS_W-1:0] idu_lsu_ins;
  logic             lsu_idu_rdy = 1'b0;
  logic             lsu_idu_wfi_done = 1'b0;
  logic             idu_err;
  logic [7:0]       idu_err_cnt;
  logic [CNT_W-1:0] idu_occ;

  always #5 clk = ~clk;

  idu_queue #(.INS_W(INS_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .ifu_idu_vld(ifu_idu_vld), .ifu_idu_ins(ifu_idu_ins), .ifu_idu_flush(ifu_idu_flush),
    .idu_ifu_rdy(idu_ifu_rdy), .idu_ifu_wfi(idu_ifu_wfi),
    .idu_lsu_vld(idu_lsu_vld), .idu_lsu_op(idu_lsu_op), .idu_lsu_sram_sel(idu_lsu_sram_sel),
    .idu_lsu_ins(idu_lsu_ins), .lsu_idu_rdy(lsu_idu_rdy), .lsu_idu_wfi_done(lsu_idu_wfi_done),
    .idu_err(idu_err), .idu_err_cnt(idu_err_cnt), .idu_occ(idu_occ)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: plain queue of instructions plus WFI-wait flag and error counters.
  logic [INS_W-1:0] mq[$];
  bit               m_wait;
  bit               m_err;
  int               m_cnt;
  logic [88:0]      exp_vec;
  wire  [88:0]      got_vec = {idu_ifu_rdy, idu_ifu_wfi, idu_lsu_vld, idu_lsu_op, idu_lsu_sram_sel,
                               idu_lsu_ins, idu_err, idu_err_cnt, idu_occ};

  function automatic bit m_legal(input logic [63:0] ins);
    logic [3:0] o = ins[63:60];
    logic [1:0] s = ins[59:58];
    case (o)
      4'h1: return (s == 2'b00) || (s == 2'b10);
      4'h2: return s != 2'b11;
      4'h3, 4'h4, 4'h5, 4'h6, 4'hF: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [6:0] m_op(input logic [63:0] ins);
    logic [3:0] o = ins[63:60];
    if (!m_legal(ins)) return 7'd0;
    if (o == 4'hF) return 7'b1000000;
    return 7'(1) << (o - 4'd1);
  endfunction

  function automatic logic [2:0] m_sel(input logic [63:0] ins);
    logic [1:0] s = ins[59:58];
    if (!m_legal(ins) || ins[63:60] > 4'h2) return 3'd0;
    if (s == 2'b00) return 3'b001;
    if (s == 2'b10) return 3'b010;
    return 3'b100;
  endfunction

  function automatic logic [63:0] r64();
    return {$urandom(), $urandom()};
  endfunction

  function automatic logic [63:0] mk(input logic [3:0] o, input logic [1:0] s);
    logic [63:0] r = r64();
    return {o, s, r[57:0]};
  endfunction

  function automatic logic [63:0] rand_ins();
    logic [3:0] o = 4'($urandom_range(0, 15));
    logic [1:0] s = 2'($urandom_range(0, 3));
    if (o > 4'h2) s = 2'b00;
    return mk(o, s);
  endfunction

  task automatic pred();
    logic [63:0] h;
    h = (mq.size() > 0) ? mq[0] : 64'd0;
    exp_vec = {(!ifu_idu_flush && mq.size() < DEPTH), m_wait,
               (!m_wait && mq.size() > 0 && m_legal(h)), m_op(h), m_sel(h), h,
               m_err, 8'(m_cnt), 3'(mq.size())};
  endtask

  task automatic drive(input logic v, input logic [63:0] i, input logic f, input logic r, input logic d);
    ifu_idu_vld = v; ifu_idu_ins = i; ifu_idu_flush = f; lsu_idu_rdy = r; lsu_idu_wfi_done = d;
    #1;
  endtask

  // Advance one clock and apply the specified rules to the model.
  task automatic tick();
    int sz;
    @(posedge clk);
    sz = mq.size();
    if (ifu_idu_flush) begin
      mq.delete();
      if (m_wait && lsu_idu_wfi_done) m_wait = 1'b0;
    end else begin
      if (m_wait) begin
        if (lsu_idu_wfi_done) m_wait = 1'b0;
      end else if (sz > 0) begin
        if (m_legal(mq[0])) begin
          if (lsu_idu_rdy) begin
            if (mq[0][63:60] == 4'hF) m_wait = 1'b1;
            void'(mq.pop_front());
          end
        end else begin
          void'(mq.pop_front());
          m_err = 1'b1;
          if (m_cnt < 255) m_cnt++;
        end
      end
      if (ifu_idu_vld && sz < DEPTH) mq.push_back(ifu_idu_ins);
    end
    #1;
  endtask

  task automatic do_reset();
    ifu_idu_vld = 1'b0; ifu_idu_flush = 1'b0; lsu_idu_rdy = 1'b0; lsu_idu_wfi_done = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    mq.delete(); m_wait = 1'b0; m_err = 1'b0; m_cnt = 0;
  endtask

  task automatic test_reset();
    do_reset();
    drive(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (idu_ifu_rdy !== 1'b1)      begin errors++; $display("FAIL reset_rdy got %b exp 1", idu_ifu_rdy); end
    checks++; if (idu_lsu_vld !== 1'b0)      begin errors++; $display("FAIL reset_vld got %b exp 0", idu_lsu_vld); end
    checks++; if (idu_ifu_wfi !== 1'b0)      begin errors++; $display("FAIL reset_wfi got %b exp 0", idu_ifu_wfi); end
    checks++; if (idu_err !== 1'b0)          begin errors++; $display("FAIL reset_err got %b exp 0", idu_err); end
    checks++; if (idu_err_cnt !== 8'd0)      begin errors++; $display("FAIL reset_err_cnt got %0d exp 0", idu_err_cnt); end
    checks++; if (idu_occ !== 3'd0)          begin errors++; $display("FAIL reset_occ got %0d exp 0", idu_occ); end
    checks++; if (idu_lsu_op !== 7'd0)       begin errors++; $display("FAIL reset_op got %b exp 0", idu_lsu_op); end
    checks++; if (idu_lsu_sram_sel !== 3'd0) begin errors++; $display("FAIL reset_sel got %b exp 0", idu_lsu_sram_sel); end
    checks++; if (idu_lsu_ins !== 64'd0)     begin errors++; $display("FAIL reset_ins got %h exp 0", idu_lsu_ins); end
  endtask

  task automatic test_fill_drain();
    logic [63:0] ins_l[4];
    do_reset();
    for (int i = 0; i < 4; i++) begin
      ins_l[i] = mk(4'h1, 2'b00);
      drive(1'b1, ins_l[i], 1'b0, 1'b0, 1'b0);
      pred(); checks++;
      if (got_vec !== exp_vec) begin errors++; $display("FAIL fill_cyc%0d got %h exp %h", i, got_vec, exp_vec); end
      tick();
    end
    drive(1'b1, mk(4'h1, 2'b00), 1'b0, 1'b0, 1'b0);
    checks++; if (idu_occ !== 3'd4)                begin errors++; $display("FAIL full_occ got %0d exp 4", idu_occ); end
    checks++; if (idu_ifu_rdy !== 1'b0)            begin errors++; $display("FAIL full_rdy got %b exp 0", idu_ifu_rdy); end
    checks++; if (idu_lsu_op !== 7'b0000001)       begin errors++; $display("FAIL full_op got %b exp 0000001", idu_lsu_op); end
    checks++; if (idu_lsu_sram_sel !== 3'b001)     begin errors++; $display("FAIL full_sel got %b exp 001", idu_lsu_sram_sel); end
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 64'd0, 1'b0, 1'b1, 1'b0);
      checks++;
      if (idu_lsu_vld !== 1'b1 || idu_lsu_ins !== ins_l[i]) begin
        errors++; $display("FAIL drain_%0d got vld %b ins %h exp vld 1 ins %h", i, idu_lsu_vld, idu_lsu_ins, ins_l[i]);
      end
      tick();
    end
    drive(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (idu_occ !== 3'd0 || idu_lsu_vld !== 1'b0) begin errors++; $display("FAIL drained got occ %0d vld %b exp 0 0", idu_occ, idu_lsu_vld); end
  endtask

  task automatic test_illegal_then_st();
    logic [63:0] st_ins;
    do_reset();
    st_ins = mk(4'h2, 2'b10);
    drive(1'b1, mk(4'h7, 2'b00), 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b1, st_ins, 1'b0, 1'b1, 1'b0);
    checks++; if (idu_lsu_vld !== 1'b0 || idu_occ !== 3'd1) begin errors++; $display("FAIL illegal_head got vld %b occ %0d exp 0 1", idu_lsu_vld, idu_occ); end
    tick();
    drive(1'b0, 64'd0, 1'b0, 1'b1, 1'b0);
    checks++; if (idu_err !== 1'b1 || idu_err_cnt !== 8'd1) begin errors++; $display("FAIL illegal_err got %b/%0d exp 1/1", idu_err, idu_err_cnt); end
    checks++;
    if (idu_lsu_vld !== 1'b1 || idu_lsu_op !== 7'b0000010 || idu_lsu_sram_sel !== 3'b010 || idu_lsu_ins !== st_ins) begin
      errors++; $display("FAIL st_wram got vld %b op %b sel %b exp 1 0000010 010", idu_lsu_vld, idu_lsu_op, idu_lsu_sram_sel);
    end
    tick();
  endtask

  task automatic test_wfi();
    do_reset();
    drive(1'b1, mk(4'hF, 2'b00), 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b1, mk(4'h4, 2'b00), 1'b0, 1'b1, 1'b0);
    checks++; if (idu_lsu_vld !== 1'b1 || idu_lsu_op !== 7'b1000000) begin errors++; $display("FAIL wfi_disp got vld %b op %b exp 1 1000000", idu_lsu_vld, idu_lsu_op); end
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 64'd0, 1'b0, 1'b1, 1'b0);
      checks++;
      if (idu_ifu_wfi !== 1'b1 || idu_lsu_vld !== 1'b0 || idu_occ !== 3'd1) begin
        errors++; $display("FAIL wfi_hold%0d got wfi %b vld %b occ %0d exp 1 0 1", i, idu_ifu_wfi, idu_lsu_vld, idu_occ);
      end
      tick();
    end
    drive(1'b0, 64'd0, 1'b0, 1'b1, 1'b1);
    checks++; if (idu_ifu_wfi !== 1'b1 || idu_lsu_vld !== 1'b0) begin errors++; $display("FAIL wfi_done_cyc got wfi %b vld %b exp 1 0", idu_ifu_wfi, idu_lsu_vld); end
    tick();
    drive(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (idu_ifu_wfi !== 1'b0 || idu_lsu_vld !== 1'b1 || idu_lsu_op !== 7'b0001000) begin
      errors++; $display("FAIL wfi_release got wfi %b vld %b op %b exp 0 1 0001000", idu_ifu_wfi, idu_lsu_vld, idu_lsu_op);
    end
    pred(); checks++;
    if (got_vec !== exp_vec) begin errors++; $display("FAIL wfi_model got %h exp %h", got_vec, exp_vec); end
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, mk(4'h5, 2'b00), 1'b0, 1'b0, 1'b0);
      tick();
    end
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, mk(4'h5, 2'b00), 1'b0, 1'b1, 1'b0);
      pred(); checks++;
      if (got_vec !== exp_vec || idu_occ !== 3'd2) begin
        errors++; $display("FAIL b2b_cyc%0d got %h exp %h", i, got_vec, exp_vec);
      end
      tick();
    end
  endtask

  task automatic test_flush();
    do_reset();
    drive(1'b1, mk(4'h9, 2'b00), 1'b0, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, mk(4'h5, 2'b00), 1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, mk(4'h6, 2'b00), 1'b1, 1'b1, 1'b0);
    checks++; if (idu_occ !== 3'd3 || idu_ifu_rdy !== 1'b0) begin errors++; $display("FAIL flush_pre got occ %0d rdy %b exp 3 0", idu_occ, idu_ifu_rdy); end
    tick();
    drive(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (idu_occ !== 3'd0 || idu_lsu_vld !== 1'b0 || idu_err_cnt !== 8'd1 || idu_err !== 1'b1) begin
      errors++; $display("FAIL flush_post got occ %0d vld %b cnt %0d err %b exp 0 0 1 1", idu_occ, idu_lsu_vld, idu_err_cnt, idu_err);
    end
    pred(); checks++;
    if (got_vec !== exp_vec) begin errors++; $display("FAIL flush_model got %h exp %h", got_vec, exp_vec); end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      drive(1'($urandom_range(0, 3) != 0), rand_ins(), 1'($urandom_range(0, 15) == 0),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0));
      pred(); checks++;
      if (got_vec !== exp_vec) begin errors++; $display("FAIL rand_cyc%0d got %h exp %h", i, got_vec, exp_vec); end
      tick();
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, mk(4'($urandom_range(7, 14)), 2'b00), 1'b0, 1'($urandom_range(0, 1)), 1'b0);
      pred(); checks++;
      if (got_vec !== exp_vec) begin errors++; $display("FAIL sat_cyc%0d got %h exp %h", i, got_vec, exp_vec); end
      tick();
    end
    drive(1'b1, mk(4'h8, 2'b00), 1'b0, 1'b0, 1'b0);
    checks++; if (idu_err_cnt !== 8'd255 || idu_err !== 1'b1) begin errors++; $display("FAIL sat_cnt got %0d err %b exp 255 1", idu_err_cnt, idu_err); end
    tick();
    drive(1'b1, mk(4'h5, 2'b00), 1'b0, 1'b0, 1'b0);
    #1 rst = 1'b1;
    #1;
    checks++;
    if (idu_ifu_rdy !== 1'b1 || idu_occ !== 3'd0 || idu_err !== 1'b0 || idu_err_cnt !== 8'd0 ||
        idu_lsu_vld !== 1'b0 || idu_lsu_ins !== 64'd0) begin
      errors++; $display("FAIL mid_reset got rdy %b occ %0d err %b cnt %0d vld %b exp 1 0 0 0 0",
                         idu_ifu_rdy, idu_occ, idu_err, idu_err_cnt, idu_lsu_vld);
    end
    ifu_idu_vld = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    mq.delete(); m_wait = 1'b0; m_err = 1'b0; m_cnt = 0;
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_illegal_then_st();
    test_wfi();
    test_back_to_back();
    test_flush();
    test_random();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
